// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: funct3 encodings, MMIO
// register offsets, the STATUS bit index and the alignment rule.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [15:0] OFF_LED    = 16'h0000;
  localparam logic [15:0] OFF_CYCLE  = 16'h0004;
  localparam logic [15:0] OFF_STATUS = 16'h0008;

  localparam int unsigned STATUS_MISALIGN_BIT = 0;

  // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0.
  function automatic logic access_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic half_acc;
    logic word_acc;
    half_acc = (f3 == F3_H) || (f3 == F3_HU);
    word_acc = (f3 == F3_W);
    return (half_acc && a[0]) || (word_acc && (a != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load formatter: picks the byte/halfword selected by the low address bits
// and sign- or zero-extends it according to funct3.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  byte_sel,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    result   = '0;
    sel_byte = raw[{byte_sel, 3'b000} +: 8];
    sel_half = byte_sel[1] ? raw[31:16] : raw[15:0];
    case (funct3)
      F3_B:    result = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    result = {{16{sel_half[15]}}, sel_half};
      F3_W:    result = raw;
      F3_BU:   result = {24'h0, sel_byte};
      F3_HU:   result = {16'h0, sel_half};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane RAM with combinational loads and an
// optional MMIO window (LED, CYCLE, STATUS) enabled by DMEM_MMIO_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        misaligned,
  output logic [15:0] led_out
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0]   ram [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic [3:0]    lane_en;
  logic [31:0]   lane_data;
  logic          is_mmio;
  logic [31:0]   mmio_rdata;
  logic          ram_we;
  logic [31:0]   raw_word;
  logic          unused_addr;

  assign word_idx    = addr[2 +: AW];
  assign misaligned  = access_misaligned(funct3, addr[1:0]);
  assign unused_addr = ^addr;

  // Store lane steering; non-store encodings enable no lanes.
  always_comb begin
    lane_en   = 4'b0000;
    lane_data = write_data;
    case (funct3)
      F3_B: begin
        lane_en   = 4'b0001 << addr[1:0];
        lane_data = {4{write_data[7:0]}};
      end
      F3_H: begin
        lane_en   = addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{write_data[15:0]}};
      end
      F3_W:    lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  end

  // Stores during reset or with bad alignment are dropped.
  assign ram_we = mem_write && reset && !misaligned && !is_mmio;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we && lane_en[i]) begin
        ram[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

`ifdef DMEM_MMIO_EN
  logic [15:0] led_q;
  logic [31:0] cycle_q;
  logic        status_q;
  logic [15:0] word_off;
  logic        mmio_we;
  logic        store_err;

  assign is_mmio   = (addr[31:16] == MMIO_BASE[31:16]);
  assign word_off  = {addr[15:2], 2'b00};
  assign mmio_we   = mem_write && is_mmio && (funct3 == F3_W) && !misaligned;
  assign store_err = mem_write && misaligned && ((funct3 == F3_H) || (funct3 == F3_W));

  // Misaligned-store set wins over a W1C in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q    <= '0;
      cycle_q  <= '0;
      status_q <= 1'b0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (mmio_we && (word_off == OFF_LED)) begin
        led_q <= write_data[15:0];
      end
      if (store_err) begin
        status_q <= 1'b1;
      end else if (mmio_we && (word_off == OFF_STATUS) && write_data[STATUS_MISALIGN_BIT]) begin
        status_q <= 1'b0;
      end
    end
  end

  always_comb begin
    mmio_rdata = '0;
    case (word_off)
      OFF_LED:    mmio_rdata = {16'h0000, led_q};
      OFF_CYCLE:  mmio_rdata = cycle_q;
      OFF_STATUS: mmio_rdata[STATUS_MISALIGN_BIT] = status_q;
      default:    mmio_rdata = '0;
    endcase
  end

  assign led_out = led_q;
`else
  assign is_mmio    = 1'b0;
  assign mmio_rdata = '0;
  assign led_out    = '0;
`endif

  assign raw_word = is_mmio ? mmio_rdata : ram[word_idx];

  dmem_load_align u_align (
    .raw      (raw_word),
    .byte_sel (addr[1:0]),
    .funct3   (funct3),
    .result   (read_data)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: byte-array reference model checked
// every cycle, plus directed literal checks. MMIO checks follow DMEM_MMIO_EN.
module tb_dmem_responder;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        misaligned;
  logic [15:0] led_out;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  // Reference model state
  logic [7:0]  mm [DEPTH*4];
  logic [15:0] m_led    = '0;
  logic [31:0] m_cyc    = '0;
  logic        m_status = 1'b0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(32'hFFFF_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .misaligned (misaligned),
    .led_out    (led_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_is_mmio(input logic [31:0] a);
`ifdef DMEM_MMIO_EN
    return a[31:16] == 16'hFFFF;
`else
    return (a == 32'h0) && 1'b0;
`endif
  endfunction

  function automatic logic model_mis(input logic [2:0] f, input logic [31:0] a);
    if ((f == 3'd1 || f == 3'd5) && a[0]) return 1'b1;
    if (f == 3'd2 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int ram_base(input logic [31:0] a);
    return int'(a[9:2]) * 4;
  endfunction

  function automatic int store_len(input logic [2:0] f);
    if (f == 3'd0) return 1;
    if (f == 3'd1) return 2;
    if (f == 3'd2) return 4;
    return 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [2:0] f);
    logic [31:0] w;
    logic [31:0] bv;
    logic [31:0] hv;
    int b;
    if (model_is_mmio(a)) begin
      if ((a[15:0] & 16'hFFFC) == 16'h0000) w = {16'h0, m_led};
      else if ((a[15:0] & 16'hFFFC) == 16'h0004) w = m_cyc;
      else if ((a[15:0] & 16'hFFFC) == 16'h0008) w = {31'h0, m_status};
      else w = 32'h0;
    end else begin
      b = ram_base(a);
      w = {mm[b+3], mm[b+2], mm[b+1], mm[b]};
    end
    bv = (w >> (8 * a[1:0])) & 32'hFF;
    hv = (w >> (16 * a[1])) & 32'hFFFF;
    case (f)
      3'd0:    return (bv >= 32'd128) ? bv - 32'd256 : bv;
      3'd1:    return (hv >= 32'd32768) ? hv - 32'd65536 : hv;
      3'd2:    return w;
      3'd4:    return bv;
      3'd5:    return hv;
      default: return 32'h0;
    endcase
  endfunction

  // Model state update: same rules the core sees, in byte terms.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_led    <= '0;
      m_cyc    <= '0;
      m_status <= 1'b0;
    end else begin
      m_cyc <= m_cyc + 32'd1;
      if (mem_write) begin
        if (model_mis(funct3, addr)) begin
          if (funct3 == 3'd1 || funct3 == 3'd2) m_status <= 1'b1;
        end else if (model_is_mmio(addr)) begin
          if (funct3 == 3'd2) begin
            if (addr[15:0] == 16'h0000) m_led <= write_data[15:0];
            else if (addr[15:0] == 16'h0008 && write_data[0]) m_status <= 1'b0;
          end
        end else begin
          for (int k = 0; k < store_len(funct3); k++) begin
            mm[ram_base(addr) + int'(addr[1:0]) + k] <= write_data[8*k +: 8];
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_read_data", read_data, model_read(addr, funct3));
      check("model_misaligned", {31'h0, misaligned}, {31'h0, model_mis(funct3, addr)});
      check("model_led_out", {16'h0, led_out}, {16'h0, m_led});
    end
  end

  task automatic drive(input logic we, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d);
    mem_write  = we;
    funct3     = f;
    addr       = a;
    write_data = d;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
  endtask

  task automatic load_chk(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] exp);
    mem_write = 1'b0;
    funct3    = f;
    addr      = a;
    #1;
    check(name, read_data, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b0;
    mem_write  = 1'b0;
    funct3     = 3'd2;
    addr       = 32'h0;
    write_data = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
`ifdef DMEM_MMIO_EN
    addr = 32'hFFFF_0004;
    #1 check("cycle_after_10", read_data, 32'd10);
    addr = 32'h0;
`endif

    // Give every RAM word a known value.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 3'd2, 32'(i * 4), {16'hC0DE, 16'(i * 4)});
    end
    chk_en = 1'b1;

    // Load formatting
    drive(1'b1, 3'd2, 32'h10, 32'h8765_4321);
    load_chk("lb_0x13", 3'd0, 32'h13, 32'hFFFF_FF87);
    load_chk("lbu_0x13", 3'd4, 32'h13, 32'h0000_0087);
    load_chk("lh_0x12", 3'd1, 32'h12, 32'hFFFF_8765);
    load_chk("lw_0x10", 3'd2, 32'h10, 32'h8765_4321);
    load_chk("lh_mis_trunc", 3'd1, 32'h11, 32'h0000_4321);
    load_chk("load_f3_011", 3'd3, 32'h10, 32'h0);

    // Non-store funct3 writes nothing
    drive(1'b1, 3'd4, 32'h10, 32'h0);
    load_chk("bad_f3_store", 3'd2, 32'h10, 32'h8765_4321);

    // Byte-lane merging
    drive(1'b1, 3'd2, 32'h20, 32'hFFFF_FFFF);
    drive(1'b1, 3'd0, 32'h21, 32'h0000_0000);
    drive(1'b1, 3'd1, 32'h22, 32'h0000_1234);
    load_chk("merge_0x20", 3'd2, 32'h20, 32'h1234_00FF);

    // Misaligned store suppressed
    mem_write  = 1'b1;
    funct3     = 3'd2;
    addr       = 32'h3;
    write_data = 32'hAAAA_AAAA;
    #1 check("sw_mis_flag", {31'h0, misaligned}, 32'h1);
    @(posedge clk);
    #1 mem_write = 1'b0;
    load_chk("mis_word0_kept", 3'd2, 32'h0, 32'hC0DE_0000);
`ifdef DMEM_MMIO_EN
    load_chk("status_set", 3'd2, 32'hFFFF_0008, 32'h1);
    drive(1'b1, 3'd2, 32'hFFFF_0008, 32'h1);
    load_chk("status_w1c", 3'd2, 32'hFFFF_0008, 32'h0);
    drive(1'b1, 3'd2, 32'hFFFF_0009, 32'h1);
    load_chk("status_mis_prio", 3'd2, 32'hFFFF_0008, 32'h1);
`endif

    // Address wrap
    drive(1'b1, 3'd2, 32'h400, 32'h0000_005A);
    load_chk("wrap_0x400", 3'd2, 32'h0, 32'h0000_005A);

`ifdef DMEM_MMIO_EN
    drive(1'b1, 3'd2, 32'hFFFF_0000, 32'hABCD_1234);
    check("led_after_sw", {16'h0, led_out}, 32'h0000_1234);
    load_chk("led_read", 3'd2, 32'hFFFF_0000, 32'h0000_1234);
    drive(1'b1, 3'd1, 32'hFFFF_0000, 32'h0000_5555);
    check("led_subword_ign", {16'h0, led_out}, 32'h0000_1234);
`endif

    // Asynchronous reset mid-run; store during reset is dropped
    mem_write = 1'b0;
    funct3    = 3'd2;
    addr      = 32'hFFFF_0004;
    reset     = 1'b0;
    #1 check("led_async_rst", {16'h0, led_out}, 32'h0);
`ifdef DMEM_MMIO_EN
    check("cycle_async_rst", read_data, 32'h0);
`endif
    mem_write  = 1'b1;
    addr       = 32'h40;
    write_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    reset     = 1'b1;
    load_chk("rst_store_drop", 3'd2, 32'h40, 32'hC0DE_0040);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle RISC-V core. Receives the core's data-side access (ALU address, store data, write enable, funct3) and returns load data in the same cycle. Performs byte-lane merging for stores, sign/zero extension for loads and misalignment checking, and optionally exposes a small memory-mapped I/O window (LED register, cycle counter, error status).

## Interface
- DEPTH_WORDS, 256: RAM depth in 32-bit words; power of two.
- MMIO_BASE, 32'hFFFF_0000: base of the 64 KiB MMIO window; upper 16 bits are compared.
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; named as elsewhere in the core.
- mem_write  in  1  store request for this cycle.
- funct3  in  3  access size and sign, taken from the instruction.
- addr  in  32  byte address (ALU result).
- write_data  in  32  store data (rs2); the low byte or halfword is used for SB/SH.
- read_data  out  32  formatted load data; combinational.
- misaligned  out  1  combinational flag: the current access violates alignment.
- led_out  out  16  LED register contents.

## Operation
- Decode: MMIO when DMEM_MMIO_EN is defined and addr[31:16]==MMIO_BASE[31:16]; otherwise RAM.
- RAM word index is addr[2 +: log2(DEPTH_WORDS)]; higher bits are ignored, so the address wraps modulo the RAM size.
- Store encodings: 000 SB, 001 SH, 010 SW.
  - Byte lanes are selected by addr[1:0]; untouched lanes keep their old value.
  - Any other funct3 with mem_write=1 writes nothing.
- Load encodings:
  - 000 LB: sign-extended byte.
  - 001 LH: sign-extended halfword.
  - 010 LW: full word.
  - 100 LBU: zero-extended byte.
  - 101 LHU: zero-extended halfword.
  - Any other encoding returns 0.
  - The byte or halfword is selected by addr[1:0] (halfword by addr[1]).
- Misalignment:
  - Halfword access with addr[0]=1, or word access with addr[1:0]!=0, asserts misaligned.
  - A misaligned store is suppressed and sets the sticky error bit.
  - A misaligned load still returns data from the truncated aligned address.
- RAM contents are not cleared by reset and are undefined after power-up.
- read_data is driven every cycle regardless of mem_write. The core ignores it for non-load instructions.
- MMIO registers are word-access only; a sub-word store to MMIO is ignored.
  - +0x0 LED: read/write; bits [15:0] drive led_out; bits [31:16] read as 0.
  - +0x4 CYCLE: read-only, 32-bit free-running counter that increments every cycle and wraps 0xFFFF_FFFF→0; writes are ignored.
  - +0x8 STATUS: bit0 is the sticky misaligned-store flag; writing 1 to bit0 clears it; other bits read 0.
  - Unmapped MMIO offsets read 0; writes to them are ignored.
- Simultaneous events: a misaligned store that sets STATUS takes priority over a W1C to STATUS. In practice one core cycle carries one access, so this only arises if a misaligned SW targets STATUS itself, and it must then leave bit0=1.

## Timing
- Loads have zero latency: read_data depends combinationally on addr, funct3 and the stored state.
- Stores commit on the rising clk edge and are visible to a load in the next cycle.
- Read-during-write to the same address in one cycle returns the old value.
- Reset (reset=0) is asynchronous:
  - led_out=0, CYCLE=0, STATUS=0.
  - read_data follows the current address (for MMIO, the reset values).
  - misaligned stays combinational.
- A store presented in a cycle during which reset is low is dropped.
- CYCLE counts its first increment on the first rising edge after reset deasserts.

## Configuration
- DMEM_MMIO_EN defined: MMIO window, LED, CYCLE and STATUS registers are present as above.
- DMEM_MMIO_EN undefined:
  - All addresses map to RAM (wrapping).
  - led_out is tied to 0.
  - Misaligned stores are still suppressed, but no status is recorded.

## Structure
- Package dmem_pkg holds:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - MMIO offsets: OFF_LED=0x0, OFF_CYCLE=0x4, OFF_STATUS=0x8.
  - The STATUS bit index.
- One sub-module, dmem_load_align: pure combinational formatter taking raw word, addr[1:0] and funct3, and returning the extended result. It is reused for both RAM and MMIO read paths.
- RAM is a plain reg array with byte-lane write enables, inferable as distributed RAM.

## Test plan
- SW 0x8765_4321 to 0x10, then LB/LBU at 0x13 → 0xFFFF_FF87 / 0x0000_0087; LH at 0x12 → 0xFFFF_8765; LW at 0x10 → 0x8765_4321.
- SW 0xFFFF_FFFF to 0x20, SB 0x00 to 0x21, SH 0x1234 to 0x22 → LW 0x20 = 0x1234_00FF.
- SW 0xAAAA_AAAA to 0x3 → misaligned=1, word at 0x0 unchanged, STATUS=1; then SW 1 to 0xFFFF_0008 → STATUS=0.
- Address 0x400 with DEPTH_WORDS=256: SW 0x5A to 0x400 → LW 0x0 = 0x5A (wrap).
- Release reset, idle 10 cycles, then LW 0xFFFF_0004 → 10. SW 0xABCD_1234 to 0xFFFF_0000 → led_out=0x1234 next cycle, LW reads 0x0000_1234.
- Assert reset mid-run with LED=0x1234 and CYCLE>0 → led_out=0 and CYCLE=0 immediately (no clock edge); a store asserted during reset leaves RAM unchanged.
